// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream building-block library.
package stream_pkg;

  // Width of each per-output transfer counter.
  localparam int unsigned XFER_W = 32;

  // Handshake pair, convenient for benches that bundle valid/ready.
  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  // Select width for n outputs; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry pipeline register for a valid/ready stream.
module stream_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             can_load,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q,
  output logic             fire
);

  // The slot can take a beat when empty or when its current beat leaves this cycle.
  assign can_load = !valid_q || out_ready;
  assign fire     = valid_q && out_ready;

  // A load wins over a drain so a simultaneous handshake+load keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_in;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with drop and transfer counters.
module stream_demux
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned DROP_W = 16,
  localparam int unsigned SEL_W = sel_width(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*WIDTH-1:0]  out_data,
  output logic [DROP_W-1:0]       drop_count,
  output logic [N_OUT*XFER_W-1:0] xfer_count
);

  logic [N_OUT-1:0]  load;
  logic [N_OUT-1:0]  can_load;
  logic [N_OUT-1:0]  fire;
  logic              sel_ok;
  logic              accept;
  logic              drop;
  logic [DROP_W-1:0] drop_q;
  logic [XFER_W-1:0] xfer_q [N_OUT];

  // Ready follows the selected slot; out-of-range selects are always accepted (and dropped).
  always_comb begin
    in_ready = 1'b1;
    sel_ok   = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (in_sel == SEL_W'(i)) begin
        sel_ok   = 1'b1;
        in_ready = can_load[i];
      end
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !sel_ok;

  // Decode the accepted beat to a single slot load.
  always_comb begin
    load = '0;
    for (int i = 0; i < N_OUT; i++) begin
      load[i] = accept && (in_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    stream_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .data_in  (in_data),
      .out_ready(out_ready[g]),
      .can_load (can_load[g]),
      .valid_q  (out_valid[g]),
      .data_q   (out_data[g*WIDTH +: WIDTH]),
      .fire     (fire[g])
    );

    assign xfer_count[g*XFER_W +: XFER_W] = xfer_q[g];
  end

  // Saturating count of beats discarded for a bad select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_count = drop_q;

  // Per-output handshake counters, wrapping; only written on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) begin
        xfer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (fire[i]) begin
          xfer_q[i] <= xfer_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 2-output instance and a 3-output instance with a tiny drop counter.
module tb_stream_demux;

  logic clk;
  logic rst_n;

  // Two-output instance, 32-bit data.
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic [0:0]  a_sel;
  logic [1:0]  a_out_valid;
  logic [1:0]  a_out_ready;
  logic [63:0] a_out_data;
  logic [15:0] a_drop;
  logic [63:0] a_xfer;

  // Three-output instance, 8-bit data, 2-bit drop counter.
  logic        b_valid;
  logic        b_ready;
  logic [7:0]  b_data;
  logic [1:0]  b_sel;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic [23:0] b_out_data;
  logic [1:0]  b_drop;
  logic [95:0] b_xfer;

  int n_checks;
  int n_fail;

  stream_demux #(
    .WIDTH (32),
    .N_OUT (2),
    .DROP_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .in_data   (a_data),
    .in_sel    (a_sel),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .drop_count(a_drop),
    .xfer_count(a_xfer)
  );

  stream_demux #(
    .WIDTH (8),
    .N_OUT (3),
    .DROP_W(2)
  ) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_valid),
    .in_ready  (b_ready),
    .in_data   (b_data),
    .in_sel    (b_sel),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .drop_count(b_drop),
    .xfer_count(b_xfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_out_ready = 2'b01;
    a_valid = 1'b1; a_sel = 1'b0; a_data = 32'h11;
    step();
    a_sel = 1'b1; a_data = 32'h77;
    step();
    a_valid = 1'b0;
    step();
    n_checks++;
    if (a_out_valid !== 2'b10) begin
      n_fail++; $display("FAIL pre_reset_valid: got %b expected %b", a_out_valid, 2'b10);
    end
    n_checks++;
    if (a_xfer[31:0] !== 32'd1) begin
      n_fail++; $display("FAIL pre_reset_xfer0: got %0d expected 1", a_xfer[31:0]);
    end
    // Asynchronous assert mid-cycle with slot 1 full.
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_out_valid !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 00", a_out_valid);
    end
    n_checks++;
    if (a_out_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", a_out_data);
    end
    n_checks++;
    if (a_xfer !== 64'h0 || a_drop !== 16'h0) begin
      n_fail++; $display("FAIL reset_counts: got xfer %h drop %h expected 0 0", a_xfer, a_drop);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_sel = 1'b1; a_out_ready = 2'b00;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", a_ready);
    end
  endtask

  task automatic test_routing();
    a_out_ready = 2'b11;
    a_valid = 1'b1; a_sel = 1'b0; a_data = 32'hA5;
    step();
    n_checks++;
    if (a_out_valid !== 2'b01 || a_out_data[31:0] !== 32'hA5) begin
      n_fail++; $display("FAIL route0: got valid %b data %h expected 01 a5", a_out_valid, a_out_data[31:0]);
    end
    a_sel = 1'b1; a_data = 32'h5A;
    step();
    n_checks++;
    if (a_out_valid !== 2'b10 || a_out_data[63:32] !== 32'h5A) begin
      n_fail++; $display("FAIL route1: got valid %b data %h expected 10 5a", a_out_valid, a_out_data[63:32]);
    end
    a_valid = 1'b0;
    step();
    n_checks++;
    if (a_out_valid !== 2'b00 || a_xfer !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL route_xfer: got valid %b xfer %h expected 00 {1,1}", a_out_valid, a_xfer);
    end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 2'b10;
    a_valid = 1'b1; a_sel = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      a_data = k;
      #1;
      n_checks++;
      if (a_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready beat %0d: got %b expected 1", k, a_ready);
      end
      step();
      n_checks++;
      if (a_out_valid[1] !== 1'b1 || a_out_data[63:32] !== 32'(k)) begin
        n_fail++; $display("FAIL b2b_data beat %0d: got %b %h expected 1 %h", k, a_out_valid[1], a_out_data[63:32], k);
      end
    end
    a_valid = 1'b0;
    step();
    // One transfer from routing plus eight here.
    n_checks++;
    if (a_out_valid[1] !== 1'b0 || a_xfer[63:32] !== 32'd9) begin
      n_fail++; $display("FAIL b2b_xfer1: got %b %0d expected 0 9", a_out_valid[1], a_xfer[63:32]);
    end
  endtask

  task automatic test_stall();
    a_out_ready = 2'b00;
    a_valid = 1'b1; a_sel = 1'b0; a_data = 32'hC0;
    step();
    a_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (a_out_valid[0] !== 1'b1 || a_out_data[31:0] !== 32'hC0) begin
        n_fail++; $display("FAIL stall_hold cyc %0d: got %b %h expected 1 c0", k, a_out_valid[0], a_out_data[31:0]);
      end
    end
    // Other output is not blocked by the stalled slot.
    a_valid = 1'b1; a_sel = 1'b1; a_data = 32'hD1;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_other_ready: got %b expected 1", a_ready);
    end
    step();
    n_checks++;
    if (a_out_valid !== 2'b11 || a_out_data[63:32] !== 32'hD1) begin
      n_fail++; $display("FAIL stall_other_load: got %b %h expected 11 d1", a_out_valid, a_out_data[63:32]);
    end
    a_sel = 1'b0; a_data = 32'hC1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (a_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_blocked_ready cyc %0d: got %b expected 0", k, a_ready);
      end
      step();
      n_checks++;
      if (a_out_data[31:0] !== 32'hC0) begin
        n_fail++; $display("FAIL stall_blocked_data cyc %0d: got %h expected c0", k, a_out_data[31:0]);
      end
    end
    a_out_ready = 2'b01;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_ready: got %b expected 1", a_ready);
    end
    step();
    a_valid = 1'b0;
    n_checks++;
    if (a_out_valid[0] !== 1'b1 || a_out_data[31:0] !== 32'hC1 || a_xfer[31:0] !== 32'd2) begin
      n_fail++; $display("FAIL stall_swap: got %b %h xfer %0d expected 1 c1 2", a_out_valid[0], a_out_data[31:0], a_xfer[31:0]);
    end
    a_out_ready = 2'b11;
    step();
    n_checks++;
    if (a_out_valid !== 2'b00 || a_xfer !== {32'd10, 32'd3}) begin
      n_fail++; $display("FAIL stall_drain: got %b xfer %h expected 00 {10,3}", a_out_valid, a_xfer);
    end
  endtask

  task automatic test_bad_select();
    logic [1:0] exp_drop;
    b_out_ready = 3'b111;
    b_valid = 1'b1; b_sel = 2'd3;
    for (int k = 1; k <= 4; k++) begin
      b_data = 8'(k);
      #1;
      n_checks++;
      if (b_ready !== 1'b1) begin
        n_fail++; $display("FAIL bad_sel_ready beat %0d: got %b expected 1", k, b_ready);
      end
      step();
      exp_drop = (k >= 3) ? 2'd3 : 2'(k);
      n_checks++;
      if (b_out_valid !== 3'b000 || b_drop !== exp_drop) begin
        n_fail++; $display("FAIL bad_sel beat %0d: got valid %b drop %0d expected 000 %0d", k, b_out_valid, b_drop, exp_drop);
      end
    end
    b_sel = 2'd2; b_data = 8'h3C;
    step();
    b_valid = 1'b0;
    n_checks++;
    if (b_out_valid !== 3'b100 || b_out_data[23:16] !== 8'h3C || b_drop !== 2'd3) begin
      n_fail++; $display("FAIL sel2_route: got %b %h drop %0d expected 100 3c 3", b_out_valid, b_out_data[23:16], b_drop);
    end
  endtask

  task automatic test_wrap();
    dut.xfer_q[0] = 32'hFFFF_FFFF;
    #1;
    n_checks++;
    if (a_xfer[31:0] !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_deposit: got %h expected ffffffff", a_xfer[31:0]);
    end
    a_out_ready = 2'b01;
    a_valid = 1'b1; a_sel = 1'b0; a_data = 32'hEE;
    step();
    a_valid = 1'b0;
    step();
    n_checks++;
    if (a_xfer[31:0] !== 32'h0 || a_out_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL wrap_xfer0: got %h valid %b expected 0 0", a_xfer[31:0], a_out_valid[0]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_sel = '0; a_data = '0; a_out_ready = '0;
    b_valid = 1'b0; b_sel = '0; b_data = '0; b_out_ready = '0;
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_reset();
    test_routing();
    test_back_to_back();
    test_stall();
    test_bad_select();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
